// File: rtl/time_display.sv
// Three-digit multiplexed seven-segment driver for the game timer. It uses a
// frame-latched snapshot, leading-zero blanking, an invalid-digit dash and a saturation blink.
module time_display #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] time_1s,
  input  logic [3:0] time_10s,
  input  logic [3:0] time_100s,
  input  logic       time_max_flag,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int SCAN_DIV  = CLK_FREQ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
  localparam int SCAN_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [2:0] AN_OFF    = 3'b111;

  localparam logic [1:0] IDX_ONES = 2'd0;
  localparam logic [1:0] IDX_TENS = 2'd1;
  localparam logic [1:0] IDX_HUND = 2'd2;

  // Active-low {g,f,e,d,c,b,a}; anything above 9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         snap_1s_q, snap_1s_d;
  logic [3:0]         snap_10s_q, snap_10s_d;
  logic [3:0]         snap_100s_q, snap_100s_d;
  logic               snap_max_q, snap_max_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic [6:0]         pat_seg_q, pat_seg_d;
  logic [2:0]         pat_an_q, pat_an_d;
  logic [6:0]         seg_q, seg_d;
  logic [2:0]         an_q, an_d;

  logic scan_tick_s;
  logic frame_tick_s;

  assign scan_tick_s  = (scan_cnt_q == SCAN_LAST);
  assign frame_tick_s = scan_tick_s && (idx_q == IDX_HUND);

  // Next-state logic for scan, snapshot, digit pattern, blink and outputs.
  // The snapshot next-value doubles as the live input on the frame tick,
  // so the ones digit of a new frame decodes the values being latched.
  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    idx_d       = idx_q;
    snap_1s_d   = snap_1s_q;
    snap_10s_d  = snap_10s_q;
    snap_100s_d = snap_100s_q;
    snap_max_d  = snap_max_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    pat_seg_d   = pat_seg_q;
    pat_an_d    = pat_an_q;

    if (scan_tick_s) begin
      scan_cnt_d = {SCAN_W{1'b0}};
      case (idx_q)
        IDX_ONES: idx_d = IDX_TENS;
        IDX_TENS: idx_d = IDX_HUND;
        default:  idx_d = IDX_ONES;
      endcase
    end else begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    end

    if (frame_tick_s) begin
      snap_1s_d   = time_1s;
      snap_10s_d  = time_10s;
      snap_100s_d = time_100s;
      snap_max_d  = time_max_flag;
    end else begin
      snap_max_d  = snap_max_q;
    end

    if (scan_tick_s) begin
      case (idx_d)
        IDX_ONES: begin
          pat_seg_d = seg_decode(snap_1s_d);
          pat_an_d  = 3'b110;
        end
        IDX_TENS: begin
          if ((snap_100s_d == 4'd0) && (snap_10s_d == 4'd0)) begin
            pat_seg_d = SEG_BLANK;
            pat_an_d  = AN_OFF;
          end else begin
            pat_seg_d = seg_decode(snap_10s_d);
            pat_an_d  = 3'b101;
          end
        end
        IDX_HUND: begin
          if (snap_100s_d == 4'd0) begin
            pat_seg_d = SEG_BLANK;
            pat_an_d  = AN_OFF;
          end else begin
            pat_seg_d = seg_decode(snap_100s_d);
            pat_an_d  = 3'b011;
          end
        end
        default: begin
          pat_seg_d = SEG_BLANK;
          pat_an_d  = AN_OFF;
        end
      endcase
    end else begin
      pat_seg_d = pat_seg_q;
      pat_an_d  = pat_an_q;
    end

    // Counting starts the edge after the flag is captured, so the first
    // off phase begins exactly BLINK_DIV cycles after capture.
    if (!snap_max_d || !snap_max_q) begin
      blink_cnt_d = {BLINK_W{1'b0}};
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = {BLINK_W{1'b0}};
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      blink_on_d  = blink_on_q;
    end

    if (blink_on_d) begin
      seg_d = pat_seg_d;
      an_d  = pat_an_d;
    end else begin
      seg_d = SEG_BLANK;
      an_d  = AN_OFF;
    end
  end

  // State and output registers with asynchronous blanking reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt_q  <= {SCAN_W{1'b0}};
      idx_q       <= IDX_HUND;
      snap_1s_q   <= 4'd0;
      snap_10s_q  <= 4'd0;
      snap_100s_q <= 4'd0;
      snap_max_q  <= 1'b0;
      blink_cnt_q <= {BLINK_W{1'b0}};
      blink_on_q  <= 1'b1;
      pat_seg_q   <= SEG_BLANK;
      pat_an_q    <= AN_OFF;
      seg_q       <= SEG_BLANK;
      an_q        <= AN_OFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      snap_1s_q   <= snap_1s_d;
      snap_10s_q  <= snap_10s_d;
      snap_100s_q <= snap_100s_d;
      snap_max_q  <= snap_max_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      pat_seg_q   <= pat_seg_d;
      pat_an_q    <= pat_an_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
